// File: rtl/mem_bus_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_bus_responder : byte RAM, UART rx/tx FIFOs, cycle counter and stop   |
// | flag behind the CPU byte bus; back-pressures the CPU via cpu_rdy_o.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module mem_bus_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);
   localparam int AW = $clog2(DEPTH);

   // One extra pointer bit separates full from empty when the indices match.
   logic [AW:0]      wp_q, wp_d, rp_q, rp_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   assign empty = (wp_q == rp_q);
   assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
   assign head  = mem_q[rp_q[AW-1:0]];

   always_comb begin
      wp_d = wp_q;
      rp_d = rp_q;
      if (push && !full) wp_d = wp_q + 1'b1;
      if (pop && !empty) rp_d = rp_q + 1'b1;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         wp_q <= wp_d;
         rp_q <= rp_d;
      end
   end

   always_ff @(posedge clk_in) begin
      if (push && !full) mem_q[wp_q[AW-1:0]] <= push_data;
   end
endmodule

module mem_bus_responder #(
   parameter int RAM_ADDR_WIDTH = 17,
   parameter int FIFO_DEPTH     = 16
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_dout,
   output logic [7:0]  mem_din,
   output logic        cpu_rdy_o,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        program_finished
);
   logic [7:0]  ram [2**RAM_ADDR_WIDTH];

   logic [31:0] cnt_q, cnt_d;
   logic [31:0] snap_q, snap_d;
   logic [7:0]  mem_din_q, mem_din_d;
   logic        fin_q, fin_d;

   logic        is_io, stall, ram_we;
   logic [15:0] io_off;
   logic [RAM_ADDR_WIDTH-1:0] ram_addr;
   logic        rx_pop, rx_empty, rx_full;
   logic [7:0]  rx_head;
   logic        tx_push, tx_empty, tx_full;
   logic [7:0]  tx_push_data;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^mem_a[31:18];

   assign is_io    = (mem_a[17:16] == 2'b11);
   assign io_off   = mem_a[15:0];
   assign ram_addr = mem_a[RAM_ADDR_WIDTH-1:0];

   assign stall = is_io && (
                     (!mem_wr && io_off == 16'h0000 && rx_empty) ||
                     ( mem_wr && io_off == 16'h0000 && mem_dout != 8'h00 && tx_full) ||
                     ( mem_wr && io_off == 16'h0004 && tx_full));

   // Reset forces ready high even if the held request would otherwise stall.
   assign cpu_rdy_o        = !stall || !rst_in;
   assign mem_din          = mem_din_q;
   assign program_finished = fin_q;
   assign rx_ready         = !rx_full;
   assign tx_valid         = !tx_empty;

   mem_bus_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .push      (rx_valid),
      .push_data (rx_data),
      .pop       (rx_pop),
      .head      (rx_head),
      .empty     (rx_empty),
      .full      (rx_full)
   );

   mem_bus_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .push      (tx_push),
      .push_data (tx_push_data),
      .pop       (tx_ready),
      .head      (tx_data),
      .empty     (tx_empty),
      .full      (tx_full)
   );

   always_comb begin
      cnt_d        = cnt_q + 32'd1;
      snap_d       = snap_q;
      mem_din_d    = mem_din_q;
      fin_d        = fin_q;
      rx_pop       = 1'b0;
      tx_push      = 1'b0;
      tx_push_data = mem_dout;
      ram_we       = 1'b0;

      if (!stall) begin
         if (!is_io) begin
            if (mem_wr) ram_we = 1'b1;
            else        mem_din_d = ram[ram_addr];
         end else if (!mem_wr) begin
            if (io_off == 16'h0000) begin
               rx_pop    = 1'b1;
               mem_din_d = rx_head;
            end else if (io_off[15:2] == 14'h0001) begin
               // Byte 0 re-arms the snapshot so bytes 1..3 come from the same count.
               case (io_off[1:0])
                  2'd0: begin
                     snap_d    = cnt_q;
                     mem_din_d = cnt_q[7:0];
                  end
                  2'd1:    mem_din_d = snap_q[15:8];
                  2'd2:    mem_din_d = snap_q[23:16];
                  default: mem_din_d = snap_q[31:24];
               endcase
            end else begin
               mem_din_d = 8'h00;
            end
         end else begin
            if (io_off == 16'h0000 && mem_dout != 8'h00) begin
               tx_push = 1'b1;
            end else if (io_off == 16'h0004) begin
               tx_push      = 1'b1;
               tx_push_data = 8'h00;
               fin_d        = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         cnt_q     <= '0;
         snap_q    <= '0;
         mem_din_q <= '0;
         fin_q     <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         snap_q    <= snap_d;
         mem_din_q <= mem_din_d;
         fin_q     <= fin_d;
      end
   end

   always_ff @(posedge clk_in) begin
      if (ram_we) ram[ram_addr] <= mem_dout;
   end
endmodule

`default_nettype wire

// File: tb/tb_mem_bus_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_bus_responder : directed self-checking bench for the bus responder|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem_bus_responder;
   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic [31:0] mem_a = 32'h10;
   logic        mem_wr = 1'b0;
   logic [7:0]  mem_dout = 8'h00;
   logic [7:0]  mem_din;
   logic        cpu_rdy_o;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        program_finished;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] cyc = 32'd0;
   logic [31:0] exp_cnt;
   logic        found;

   mem_bus_responder #(.RAM_ADDR_WIDTH(17), .FIFO_DEPTH(16)) dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .mem_a            (mem_a),
      .mem_wr           (mem_wr),
      .mem_dout         (mem_dout),
      .mem_din          (mem_din),
      .cpu_rdy_o        (cpu_rdy_o),
      .rx_data          (rx_data),
      .rx_valid         (rx_valid),
      .rx_ready         (rx_ready),
      .tx_data          (tx_data),
      .tx_valid         (tx_valid),
      .tx_ready         (tx_ready),
      .program_finished (program_finished)
   );

   always #5 clk_in = ~clk_in;

   // Reference count of clock edges since reset release.
   always @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) cyc <= 32'd0;
      else         cyc <= cyc + 32'd1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic w, input logic [7:0] d);
      mem_a    = a;
      mem_wr   = w;
      mem_dout = d;
   endtask

   task automatic step();
      @(negedge clk_in);
   endtask

   task automatic idle();
      drive(32'h0000_0010, 1'b0, 8'h00);
   endtask

   initial begin
      #3;
      check("rst_mem_din", {24'h0, mem_din}, 32'h00);
      check("rst_rdy", {31'h0, cpu_rdy_o}, 32'h1);
      check("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
      check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
      check("rst_finished", {31'h0, program_finished}, 32'h0);
      step();
      rst_in = 1'b1;

      // RAM write then read
      drive(32'h0000_0010, 1'b1, 8'hA5);
      #1 check("ram_wr_rdy", {31'h0, cpu_rdy_o}, 32'h1);
      step();
      drive(32'h0000_0010, 1'b0, 8'h00);
      #1 check("ram_rd_rdy", {31'h0, cpu_rdy_o}, 32'h1);
      step();
      check("ram_rd_data", {24'h0, mem_din}, 32'hA5);

      // rx stall, push, release, pop
      drive(32'h0003_0000, 1'b0, 8'h00);
      #1 check("rx_stall", {31'h0, cpu_rdy_o}, 32'h0);
      step();
      check("rx_stall_hold_din", {24'h0, mem_din}, 32'hA5);
      rx_data = 8'h41; rx_valid = 1'b1;
      #1 check("rx_no_bypass", {31'h0, cpu_rdy_o}, 32'h0);
      step();
      rx_valid = 1'b0;
      #1 check("rx_release", {31'h0, cpu_rdy_o}, 32'h1);
      step();
      check("rx_pop_data", {24'h0, mem_din}, 32'h41);
      #1 check("rx_empty_again", {31'h0, cpu_rdy_o}, 32'h0);
      idle();
      rx_data = 8'h11; rx_valid = 1'b1;
      step();
      rx_data = 8'h22;
      step();
      rx_valid = 1'b0;
      drive(32'h0003_0000, 1'b0, 8'h00);
      step();
      check("rx_order_0", {24'h0, mem_din}, 32'h11);
      step();
      check("rx_order_1", {24'h0, mem_din}, 32'h22);
      idle();

      // tx: 0x48 then ignored 0x00, then fill to full
      drive(32'h0003_0000, 1'b1, 8'h48);
      step();
      drive(32'h0003_0000, 1'b1, 8'h00);
      #1 check("tx_zero_no_stall", {31'h0, cpu_rdy_o}, 32'h1);
      step();
      idle();
      check("tx_valid_one", {31'h0, tx_valid}, 32'h1);
      check("tx_head_48", {24'h0, tx_data}, 32'h48);
      for (int i = 0; i < 15; i++) begin
         drive(32'h0003_0000, 1'b1, 8'h50 + 8'(i));
         step();
      end
      drive(32'h0003_0000, 1'b1, 8'h99);
      #1 check("tx_full_stall", {31'h0, cpu_rdy_o}, 32'h0);
      step();
      tx_ready = 1'b1;
      #1 check("tx_full_pop_same_cycle", {31'h0, cpu_rdy_o}, 32'h0);
      check("tx_head_before_pop", {24'h0, tx_data}, 32'h48);
      step();
      tx_ready = 1'b0;
      #1 check("tx_push_after_pop", {31'h0, cpu_rdy_o}, 32'h1);
      step();
      idle();
      tx_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         check("tx_drain_data", {24'h0, tx_data}, 32'h50 + i);
         step();
      end
      check("tx_drain_17th", {24'h0, tx_data}, 32'h99);
      step();
      check("tx_drained", {31'h0, tx_valid}, 32'h0);

      // stop write
      tx_ready = 1'b0;
      drive(32'h0003_0000, 1'b1, 8'h7A);
      step();
      drive(32'h0003_0004, 1'b1, 8'h55);
      step();
      idle();
      check("stop_finished", {31'h0, program_finished}, 32'h1);
      tx_ready = 1'b1;
      check("stop_prev_byte", {24'h0, tx_data}, 32'h7A);
      step();
      check("stop_zero_valid", {31'h0, tx_valid}, 32'h1);
      check("stop_zero_byte", {24'h0, tx_data}, 32'h00);
      step();
      check("stop_drained", {31'h0, tx_valid}, 32'h0);
      tx_ready = 1'b0;
      repeat (3) step();
      check("stop_sticky", {31'h0, program_finished}, 32'h1);

      // counter snapshot coherence across a low-byte rollover
      found = 1'b0;
      for (int i = 0; i < 600 && !found; i++) begin
         if (cyc[7:0] == 8'hFF) found = 1'b1;
         else step();
      end
      check("cnt_wait", {31'h0, found}, 32'h1);
      exp_cnt = cyc;
      drive(32'h0003_0004, 1'b0, 8'h00);
      step();
      check("cnt_byte0", {24'h0, mem_din}, {24'h0, exp_cnt[7:0]});
      drive(32'h0003_0005, 1'b0, 8'h00);
      step();
      check("cnt_byte1", {24'h0, mem_din}, {24'h0, exp_cnt[15:8]});
      drive(32'h0003_0006, 1'b0, 8'h00);
      step();
      check("cnt_byte2", {24'h0, mem_din}, {24'h0, exp_cnt[23:16]});
      drive(32'h0003_0007, 1'b0, 8'h00);
      step();
      check("cnt_byte3", {24'h0, mem_din}, {24'h0, exp_cnt[31:24]});
      drive(32'h0003_0008, 1'b0, 8'h00);
      step();
      check("io_other_zero", {24'h0, mem_din}, 32'h00);

      // async reset mid-stall
      idle();
      step();
      tx_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         drive(32'h0003_0000, 1'b1, 8'h60 + 8'(i));
         step();
      end
      drive(32'h0003_0000, 1'b1, 8'h77);
      #1 check("ar_pre_stall", {31'h0, cpu_rdy_o}, 32'h0);
      check("ar_pre_din", {24'h0, mem_din}, 32'hA5);
      #2 rst_in = 1'b0;
      #1;
      check("ar_tx_valid", {31'h0, tx_valid}, 32'h0);
      check("ar_rdy", {31'h0, cpu_rdy_o}, 32'h1);
      check("ar_mem_din", {24'h0, mem_din}, 32'h00);
      check("ar_finished", {31'h0, program_finished}, 32'h0);
      check("ar_rx_ready", {31'h0, rx_ready}, 32'h1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
